// File: rtl/vend_pkg.sv
// vend_pkg: state encodings, coin constants and price/coin helpers for the vending controller
//   state_t  one-hot controller states
//   entry_t  cart entry {goods code, quantity}
//   coin_val value of coin bit i (bit0=1, 5, 10, 20, bit4=50)
//   coin_sum total value of a coin pulse vector
//   price    (10*hi + lo) * num
package vend_pkg;
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SELECT = 6'b000010,
    ST_PAY    = 6'b000100,
    ST_CHANGE = 6'b001000,
    ST_REFUND = 6'b010000,
    ST_DONE   = 6'b100000
  } state_t;
  typedef struct packed {
    logic [5:0] code;
    logic [1:0] num;
  } entry_t;
  localparam int COIN_N = 5;
  function automatic logic [6:0] coin_val(input int i);
    return i == 4 ? 7'd50 : i == 3 ? 7'd20 : i == 2 ? 7'd10 : i == 1 ? 7'd5 : 7'd1;
  endfunction
  function automatic logic [6:0] coin_sum(input logic [4:0] c);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < COIN_N; i++)
      if (c[i]) s = s + coin_val(i);
    return s;
  endfunction
  function automatic logic [7:0] price(input logic [2:0] hi, input logic [2:0] lo, input logic [1:0] n);
    return (8'(hi) * 8'd10 + 8'(lo)) * 8'(n);
  endfunction
endpackage

// File: rtl/vend_change_disp.sv
// vend_change_disp: change register with greedy one-coin-per-step dispenser
//   clk, rst_n  clock, async active-low reset
//   load        overwrite change with load_val (also used to clear)
//   load_val    new change amount
//   step        dispense one coin this cycle if change is nonzero
//   change      change still owed
//   coin        1-cycle one-hot coin, same encoding as the coin inputs
module vend_change_disp import vend_pkg::*; #(
  parameter int MONEY_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [MONEY_W-1:0] load_val,
  output logic [MONEY_W-1:0] change,
  output logic [4:0]         coin
);
  logic [4:0]         pick;
  logic [MONEY_W-1:0] pick_val;
  // Ascending scan: the last coin that fits is the largest one
  always_comb begin
    pick = '0;
    pick_val = '0;
    for (int i = 0; i < COIN_N; i++)
      if (32'(change) >= 32'(coin_val(i))) begin
        pick = '0;
        pick[i] = 1'b1;
        pick_val = MONEY_W'(coin_val(i));
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      change <= '0;
      coin <= '0;
    end else if (load) begin
      change <= load_val;
      coin <= '0;
    end else if (step && change != '0) begin
      change <= change - pick_val;
      coin <= pick;
    end else
      coin <= '0;
endmodule

// File: rtl/vend_cart_ctrl.sv
// vend_cart_ctrl: multi-item cart vending controller with timeout, greedy change and vend dispatch
//   sys_clk, sys_rst_n            clock, async active-low reset
//   sys_Goods/Confirm/Cancel/Change  1-cycle key pulses (Cancel > Confirm > Goods)
//   in_money                      coin pulses {50,20,10,5,1}
//   type_SW_high/low, num_SW      current goods code and quantity
//   state_out                     one-hot state
//   need_money/input_money/change_money  cart total, money inserted, change owed
//   change_coin                   dispensed coin pulse
//   vend_valid/code/num           per-entry dispatch strobe and payload
//   cart_count, cart_full         cart occupancy
module vend_cart_ctrl import vend_pkg::*; #(
  parameter int MONEY_W     = 10,
  parameter int CART_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int AUTO_CHANGE = 0,
  parameter int DONE_CYC    = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               sys_Goods,
  input  logic               sys_Confirm,
  input  logic               sys_Cancel,
  input  logic               sys_Change,
  input  logic [4:0]         in_money,
  input  logic [2:0]         type_SW_high,
  input  logic [2:0]         type_SW_low,
  input  logic [1:0]         num_SW,
  output logic [5:0]         state_out,
  output logic [MONEY_W-1:0] need_money,
  output logic [MONEY_W-1:0] input_money,
  output logic [MONEY_W-1:0] change_money,
  output logic [4:0]         change_coin,
  output logic               vend_valid,
  output logic [5:0]         vend_code,
  output logic [1:0]         vend_num,
  output logic [2:0]         cart_count,
  output logic               cart_full
);
  localparam int MW1 = MONEY_W + 1;
  localparam int TW = $clog2((TIMEOUT_CYC > DONE_CYC ? TIMEOUT_CYC : DONE_CYC) + 1) + 1;
  state_t             state, state_nx;
  entry_t             cart [CART_DEPTH];
  entry_t             cur, disp_entry;
  logic [2:0]         dptr;
  logic [TW-1:0]      tmr;
  logic [MW1-1:0]     need_sum, input_sum;
  logic [MONEY_W-1:0] need_add, input_add, chg_val;
  logic               can_add, add, clr, load, pulse, tmo, done_exp, disp, step;
  assign cur = {type_SW_high, type_SW_low, num_SW};
  assign cart_full = 32'(cart_count) >= CART_DEPTH;
  assign can_add = num_SW != 2'd0 && !cart_full;
  assign need_sum = {1'b0, need_money} + MW1'(price(type_SW_high, type_SW_low, num_SW));
  assign need_add = need_sum[MONEY_W] ? '1 : need_sum[MONEY_W-1:0];
  assign input_sum = {1'b0, input_money} + MW1'(coin_sum(in_money));
  assign input_add = input_sum[MONEY_W] ? '1 : input_sum[MONEY_W-1:0];
  assign pulse = |in_money | sys_Goods | sys_Confirm | sys_Cancel | sys_Change;
  // Timeout fires on the TIMEOUT_CYC-th consecutive pulse-free PAY cycle
  assign tmo = TIMEOUT_CYC != 0 && !pulse && 32'(tmr) + 1 >= TIMEOUT_CYC;
  assign done_exp = 32'(tmr) + 1 >= DONE_CYC;
  assign disp = state == ST_CHANGE && dptr < cart_count;
  assign step = (state == ST_CHANGE || state == ST_REFUND) && (sys_Change || AUTO_CHANGE != 0);
  assign state_out = state;
  always_comb begin
    disp_entry = '0;
    for (int i = 0; i < CART_DEPTH; i++)
      if (dptr == 3'(i)) disp_entry = cart[i];
  end
  always_comb begin
    state_nx = state;
    add = 1'b0;
    clr = 1'b0;
    load = 1'b0;
    chg_val = '0;
    case (state)
      ST_IDLE:
        if (sys_Confirm) begin
          state_nx = ST_SELECT;
          clr = 1'b1;
        end
      ST_SELECT:
        if (sys_Cancel) begin
          state_nx = ST_IDLE;
          clr = 1'b1;
        end else if (sys_Confirm || sys_Goods) begin
          add = can_add;
          if (sys_Confirm && (can_add ? need_add : need_money) != '0) state_nx = ST_PAY;
        end
      ST_PAY:
        if (sys_Cancel || tmo) begin
          state_nx = ST_REFUND;
          load = 1'b1;
          chg_val = input_add;
        end else if (sys_Confirm && input_add >= need_money) begin
          state_nx = ST_CHANGE;
          load = 1'b1;
          chg_val = input_add - need_money;
        end
      ST_CHANGE: state_nx = change_money == '0 && !disp ? ST_DONE : ST_CHANGE;
      ST_REFUND: state_nx = change_money == '0 ? ST_DONE : ST_REFUND;
      ST_DONE:
        if (sys_Confirm) begin
          state_nx = ST_SELECT;
          clr = 1'b1;
        end else if (done_exp)
          state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      need_money <= '0;
      input_money <= '0;
      cart_count <= '0;
      dptr <= '0;
      tmr <= '0;
      vend_valid <= 1'b0;
      vend_code <= '0;
      vend_num <= '0;
      for (int i = 0; i < CART_DEPTH; i++) cart[i] <= '0;
    end else begin
      tmr <= (state_nx != state || (state == ST_PAY && pulse)) ? '0 : tmr + 1'b1;
      vend_valid <= disp;
      if (disp) begin
        vend_code <= disp_entry.code;
        vend_num <= disp_entry.num;
        dptr <= dptr + 3'd1;
      end
      if (clr) begin
        need_money <= '0;
        input_money <= '0;
        cart_count <= '0;
        dptr <= '0;
      end else begin
        if (add) begin
          need_money <= need_add;
          cart_count <= cart_count + 3'd1;
          for (int i = 0; i < CART_DEPTH; i++)
            if (cart_count == 3'(i)) cart[i] <= cur;
        end
        if (state == ST_PAY) input_money <= input_add;
      end
    end
  vend_change_disp #(.MONEY_W(MONEY_W)) u_chg (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (load | clr),
    .step     (step),
    .load_val (chg_val),
    .change   (change_money),
    .coin     (change_coin)
  );
endmodule
